// File: rtl/cache_fill_fsm_if.sv
// cache_fill_fsm_if: miss/return inputs and fill/write outputs between a cache, its fill controller and main memory
interface cache_fill_fsm_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 3
);
    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              memory_data_valid;
    logic              fsm_busy;
    logic              mem_read_en;
    logic [ADDR_W-1:0] memory_address;
    logic              write_data_array;
    logic [CNT_W-1:0]  word_index;
    logic              write_tag_array;
    logic              fill_done;

    modport master (
        output miss_detected, miss_address, memory_data_valid,
        input  fsm_busy, mem_read_en, memory_address, write_data_array,
               word_index, write_tag_array, fill_done
    );

    modport slave (
        input  miss_detected, miss_address, memory_data_valid,
        output fsm_busy, mem_read_en, memory_address, write_data_array,
               word_index, write_tag_array, fill_done
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches a missed cache block word by word from main memory and writes it plus its tag into the cache
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16
) (
    input logic            clk,
    input logic            rst_n,
    cache_fill_fsm_if.slave bus
);
    localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
    localparam int OFF_W = CNT_W + 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state_q, state_d;
    logic [CNT_W:0]    issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;

    // State, counters and block base register; reset aborts any fill in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            base_q      <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            base_q      <= base_d;
        end
    end

    // Next state and outputs: capture on miss, issue reads until all sent, write returns until the last word
    always_comb begin
        state_d              = state_q;
        issue_cnt_d          = issue_cnt_q;
        recv_cnt_d           = recv_cnt_q;
        base_d               = base_q;
        bus.fsm_busy         = 1'b0;
        bus.mem_read_en      = 1'b0;
        bus.memory_address   = '0;
        bus.write_data_array = 1'b0;
        bus.word_index       = '0;
        bus.write_tag_array  = 1'b0;
        bus.fill_done        = 1'b0;
        if (state_q == IDLE) begin
            if (bus.miss_detected) begin
                state_d     = FILL;
                base_d      = {bus.miss_address[ADDR_W-1:OFF_W], OFF_W'(0)};
                issue_cnt_d = '0;
                recv_cnt_d  = '0;
            end
        end else begin
            bus.fsm_busy         = 1'b1;
            bus.mem_read_en      = issue_cnt_q < OFF_W'(WORDS_PER_BLOCK);
            bus.memory_address   = base_q + (ADDR_W'(issue_cnt_q) << 1);
            issue_cnt_d          = bus.mem_read_en ? issue_cnt_q + OFF_W'(1) : issue_cnt_q;
            bus.write_data_array = bus.memory_data_valid;
            bus.word_index       = recv_cnt_q;
            recv_cnt_d           = bus.memory_data_valid ? recv_cnt_q + CNT_W'(1) : recv_cnt_q;
            if (bus.memory_data_valid && recv_cnt_q == CNT_W'(WORDS_PER_BLOCK - 1)) begin
                bus.write_tag_array = 1'b1;
                bus.fill_done       = 1'b1;
                state_d             = IDLE;
            end
        end
    end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed vector table plus scripted fill sequences for cache_fill_fsm
module tb_cache_fill_fsm;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    cache_fill_fsm_if bus();

    cache_fill_fsm dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rn;
        logic        miss;
        logic [15:0] a;
        logic        v;
        logic        busy;
        logic        rd;
        logic [15:0] maddr;
        logic        wr;
        logic [2:0]  idx;
        logic        tag;
        logic        done;
    } vec_t;

    vec_t vec [15];

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    task automatic cyc(input logic rn, input logic miss, input logic [15:0] a, input logic v);
        @(negedge clk);
        rst_n                 = rn;
        bus.miss_detected     = miss;
        bus.miss_address      = a;
        bus.memory_data_valid = v;
        #1;
    endtask

    task automatic chk_idle(input string n);
        chk({n, "_busy"}, 16'(bus.fsm_busy), 16'd0);
        chk({n, "_rd"},   16'(bus.mem_read_en), 16'd0);
        chk({n, "_addr"}, bus.memory_address, 16'd0);
        chk({n, "_wr"},   16'(bus.write_data_array), 16'd0);
        chk({n, "_idx"},  16'(bus.word_index), 16'd0);
        chk({n, "_tag"},  16'(bus.write_tag_array), 16'd0);
        chk({n, "_done"}, 16'(bus.fill_done), 16'd0);
    endtask

    // One complete fill from capture to the cycle after fill_done, with in-order returns and random bubbles
    task automatic do_fill(input logic [15:0] a, input int gap_max, input logic hold_miss);
        logic [15:0] base;
        int nrd, nwr, ntag, pend, gap;
        logic v;
        base = {a[15:4], 4'h0};
        nrd = 0; nwr = 0; ntag = 0; pend = 0; gap = 0;
        cyc(1'b1, 1'b1, a, 1'b0);
        chk("cap_busy", 16'(bus.fsm_busy), 16'd0);
        chk("cap_rd", 16'(bus.mem_read_en), 16'd0);
        for (int t = 0; t < 100 && nwr < 8; t++) begin
            v = (pend > 0) && (gap == 0);
            cyc(1'b1, hold_miss, 16'h4000, v);
            chk("fill_busy", 16'(bus.fsm_busy), 16'd1);
            chk("fill_rd", 16'(bus.mem_read_en), 16'(nrd < 8));
            ntag += int'(bus.write_tag_array);
            if (nrd < 8) begin
                chk("fill_addr", bus.memory_address, base + 16'(2 * nrd));
                nrd++;
                pend++;
            end
            chk("fill_wr", 16'(bus.write_data_array), 16'(v));
            if (v) begin
                chk("fill_idx", 16'(bus.word_index), 16'(nwr));
                chk("fill_tag", 16'(bus.write_tag_array), 16'(nwr == 7));
                chk("fill_done", 16'(bus.fill_done), 16'(nwr == 7));
                nwr++;
                pend--;
                gap = int'($urandom_range(0, gap_max));
            end else begin
                chk("fill_tag_idle", 16'(bus.write_tag_array), 16'd0);
                chk("fill_done_idle", 16'(bus.fill_done), 16'd0);
                if (gap > 0) gap--;
            end
        end
        chk("fill_words", 16'(nwr), 16'd8);
        chk("fill_tag_count", 16'(ntag), 16'd1);
        cyc(1'b1, hold_miss, a, 1'b0);
        chk("post_busy", 16'(bus.fsm_busy), 16'd0);
        chk("post_wr", 16'(bus.write_data_array), 16'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.miss_detected = 1'b0;
        bus.miss_address = '0;
        bus.memory_data_valid = 1'b0;
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0);

        // Fill of 0x1234 with returns three cycles after each read; stray miss mid-fill and in the done cycle
        vec[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0};
        vec[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0};
        vec[2]  = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0};
        vec[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1230, 1'b0, 3'd0, 1'b0, 1'b0};
        vec[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1232, 1'b0, 3'd0, 1'b0, 1'b0};
        vec[5]  = '{1'b1, 1'b1, 16'h4000, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 3'd0, 1'b0, 1'b0};
        vec[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1236, 1'b1, 3'd0, 1'b0, 1'b0};
        vec[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1238, 1'b1, 3'd1, 1'b0, 1'b0};
        vec[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h123A, 1'b1, 3'd2, 1'b0, 1'b0};
        vec[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h123C, 1'b1, 3'd3, 1'b0, 1'b0};
        vec[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h123E, 1'b1, 3'd4, 1'b0, 1'b0};
        vec[11] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd5, 1'b0, 1'b0};
        vec[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd6, 1'b0, 1'b0};
        vec[13] = '{1'b1, 1'b1, 16'h4000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd7, 1'b1, 1'b1};
        vec[14] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0};
        for (int i = 0; i < 15; i++) begin
            cyc(vec[i].rn, vec[i].miss, vec[i].a, vec[i].v);
            chk($sformatf("vec%0d_busy", i), 16'(bus.fsm_busy), 16'(vec[i].busy));
            chk($sformatf("vec%0d_rd", i), 16'(bus.mem_read_en), 16'(vec[i].rd));
            if (vec[i].rd || !vec[i].busy)
                chk($sformatf("vec%0d_addr", i), bus.memory_address, vec[i].maddr);
            chk($sformatf("vec%0d_wr", i), 16'(bus.write_data_array), 16'(vec[i].wr));
            chk($sformatf("vec%0d_idx", i), 16'(bus.word_index), 16'(vec[i].idx));
            chk($sformatf("vec%0d_tag", i), 16'(bus.write_tag_array), 16'(vec[i].tag));
            chk($sformatf("vec%0d_done", i), 16'(bus.fill_done), 16'(vec[i].done));
        end

        // Irregular return gaps
        do_fill(16'h5678, 3, 1'b0);
        // Miss for another block held during a fill is ignored, then a fresh miss fills that block
        do_fill(16'h0AB7, 2, 1'b1);
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        do_fill(16'h4000, 1, 1'b0);

        // Reset while word 5 is written aborts the fill without a tag write
        cyc(1'b1, 1'b1, 16'h2222, 1'b0);
        for (int k = 0; k < 7; k++) begin
            cyc(k == 6 ? 1'b0 : 1'b1, 1'b0, 16'h0, k >= 1);
            chk("rst_busy", 16'(bus.fsm_busy), 16'd1);
            chk("rst_addr", bus.memory_address, 16'h2220 + 16'(2 * k));
            chk("rst_wr", 16'(bus.write_data_array), 16'(k >= 1));
            chk("rst_idx", 16'(bus.word_index), 16'(k >= 1 ? k - 1 : 0));
            chk("rst_tag", 16'(bus.write_tag_array), 16'd0);
        end
        cyc(1'b1, 1'b0, 16'h0, 1'b1);
        chk_idle("after_rst");
        do_fill(16'h2222, 1, 1'b0);

        // Top-of-memory block with no address wrap, then stray returns while idle
        do_fill(16'hFFFF, 2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 16'h0, 1'b1);
            chk_idle("stray");
        end

        // Miss held high: the post-fill cycle captures and the next cycle is already filling
        do_fill(16'h3456, 0, 1'b1);
        cyc(1'b1, 1'b1, 16'h3456, 1'b0);
        chk("b2b_busy", 16'(bus.fsm_busy), 16'd1);
        chk("b2b_rd", 16'(bus.mem_read_en), 16'd1);
        chk("b2b_addr", bus.memory_address, 16'h3450);
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        chk_idle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
